// File: rtl/dds_lfm_burst.sv
// -----------------------------------------------------------------------------
// dds_lfm_burst
// Runtime-programmable LFM (chirp) DDS burst generator. A burst is configured
// from cfg_* at start acceptance (latched into shadow registers), then issues
// one phase per clock into a 3-stage quarter-wave sine LUT pipe.
//
// Optional feature macro: DDS_IQ_EN
//   defined   : second LUT read on phase + 90 deg drives o_dout_q (dual-read ROM)
//   undefined : o_dout_q absent, single ROM read
//
// Ports
//   i_clk        sample clock
//   i_rst_n      asynchronous active-low reset
//   i_cfg_ftw0   start FTW (unsigned)
//   i_cfg_dftw   FTW increment per sample (two's complement)
//   i_cfg_len    samples per sweep leg (0 = start ignored)
//   i_cfg_mode   00 single up, 01 repeat, 10 triangle, 11 single up
//   i_start      begin burst (sampled in IDLE only)
//   i_stop       abort burst (RUN states only)
//   o_busy       high from start acceptance until done
//   o_done       1-cycle pulse at burst end
//   o_dout_valid o_dout holds a burst sample
//   o_dout       signed sine sample (0 when not valid)
//   o_dout_q     signed cosine sample (DDS_IQ_EN only)
//
// The quarter-wave ROM is computed at elaboration:
//   entry k = round(A*sin(2*pi*k/2^LUT_BITS)), k = 0 .. 2^(LUT_BITS-2)
// -----------------------------------------------------------------------------
module dds_lfm_burst #(
    parameter int N_PHASE   = 32,
    parameter int LUT_BITS  = 10,
    parameter int OUT_WIDTH = 16,
    parameter int LEN_WIDTH = 20
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [N_PHASE-1:0]          i_cfg_ftw0,
    input  logic [N_PHASE-1:0]          i_cfg_dftw,
    input  logic [LEN_WIDTH-1:0]        i_cfg_len,
    input  logic [1:0]                  i_cfg_mode,
    input  logic                        i_start,
    input  logic                        i_stop,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_dout_valid,
    output logic signed [OUT_WIDTH-1:0] o_dout
`ifdef DDS_IQ_EN
    ,
    output logic signed [OUT_WIDTH-1:0] o_dout_q
`endif
);

    localparam int QTR = 1 << (LUT_BITS - 2);
    localparam int AMP = (1 << (OUT_WIDTH - 1)) - 1;
    localparam logic [LUT_BITS-2:0] QTR_IDX = {1'b1, {(LUT_BITS-2){1'b0}}};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN_UP = 2'd1;
    localparam logic [1:0] ST_RUN_DN = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    localparam logic [1:0] MODE_REPEAT   = 2'b01;
    localparam logic [1:0] MODE_TRIANGLE = 2'b10;

    // ---------------------------------------------------------------- ROM
    function automatic logic [(QTR+1)*OUT_WIDTH-1:0] f_rom_init();
        logic [(QTR+1)*OUT_WIDTH-1:0] rom;
        real x;
        int  v;
        rom = '0;
        for (int k = 0; k <= QTR; k++) begin
            x = real'(AMP) * $sin(2.0 * 3.141592653589793 * real'(k) / real'(4 * QTR));
            v = $rtoi(x + 0.5);
            rom[k*OUT_WIDTH +: OUT_WIDTH] = v[OUT_WIDTH-1:0];
        end
        return rom;
    endfunction

    localparam logic [(QTR+1)*OUT_WIDTH-1:0] ROM_INIT = f_rom_init();

    logic [OUT_WIDTH-1:0] w_rom [0:QTR];

    for (genvar g = 0; g <= QTR; g++) begin : g_rom
        assign w_rom[g] = ROM_INIT[g*OUT_WIDTH +: OUT_WIDTH];
    end

    // Top LUT_BITS of phase -> {sign, quarter-wave index}. In the mirrored
    // quadrants the index runs backwards from QTR, which needs the extra entry.
    function automatic logic [LUT_BITS-1:0] f_lut_addr(input logic [LUT_BITS-1:0] p);
        logic [LUT_BITS-3:0] k;
        logic [LUT_BITS-2:0] idx;
        k   = p[LUT_BITS-3:0];
        idx = p[LUT_BITS-2] ? (QTR_IDX - {1'b0, k}) : {1'b0, k};
        return {p[LUT_BITS-1], idx};
    endfunction

    // ---------------------------------------------------------------- control
    logic [1:0]           r_state;
    logic [1:0]           r_flush_cnt;
    logic [N_PHASE-1:0]   r_phase;
    logic [N_PHASE-1:0]   r_ftw;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic [N_PHASE-1:0]   r_ftw0;
    logic [N_PHASE-1:0]   r_dftw;
    logic [LEN_WIDTH-1:0] r_len;
    logic [1:0]           r_mode;

    logic                 w_running;
    logic                 w_issue;
    logic                 w_last;
    logic [N_PHASE-1:0]   w_ftw_step;

    assign w_running  = (r_state == ST_RUN_UP) || (r_state == ST_RUN_DN);
    // A stop cycle is not issued.
    assign w_issue    = w_running && !i_stop;
    assign w_last     = (r_cnt == (r_len - LEN_WIDTH'(1)));
    assign w_ftw_step = (r_state == ST_RUN_DN) ? (r_ftw - r_dftw) : (r_ftw + r_dftw);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= 2'd0;
            r_phase     <= '0;
            r_ftw       <= '0;
            r_cnt       <= '0;
            r_ftw0      <= '0;
            r_dftw      <= '0;
            r_len       <= '0;
            r_mode      <= 2'b00;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // start outranks stop here; stop is simply not looked at
                    if (i_start && (i_cfg_len != '0)) begin
                        r_ftw0  <= i_cfg_ftw0;
                        r_dftw  <= i_cfg_dftw;
                        r_len   <= i_cfg_len;
                        r_mode  <= i_cfg_mode;
                        r_phase <= '0;
                        r_ftw   <= i_cfg_ftw0;
                        r_cnt   <= '0;
                        o_busy  <= 1'b1;
                        r_state <= ST_RUN_UP;
                    end
                end
                ST_RUN_UP, ST_RUN_DN: begin
                    if (i_stop) begin
                        r_flush_cnt <= 2'd0;
                        r_state     <= ST_FLUSH;
                    end else begin
                        r_phase <= r_phase + r_ftw;
                        if (w_last) begin
                            r_cnt <= '0;
                            if (r_mode == MODE_REPEAT) begin
                                r_ftw <= r_ftw0;
                            end else if ((r_mode == MODE_TRIANGLE) && (r_state == ST_RUN_UP)) begin
                                r_ftw   <= w_ftw_step;
                                r_state <= ST_RUN_DN;
                            end else begin
                                r_ftw       <= w_ftw_step;
                                r_flush_cnt <= 2'd0;
                                r_state     <= ST_FLUSH;
                            end
                        end else begin
                            r_cnt <= r_cnt + LEN_WIDTH'(1);
                            r_ftw <= w_ftw_step;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == 2'd2) begin
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 2'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- LUT pipe
    logic [LUT_BITS-1:0]  w_addr_i;
    logic                 r_s1_vld;
    logic                 r_s1_sign;
    logic [LUT_BITS-2:0]  r_s1_idx;
    logic                 r_s2_vld;
    logic                 r_s2_sign;
    logic [OUT_WIDTH-1:0] r_s2_mag;

    assign w_addr_i = f_lut_addr(r_phase[N_PHASE-1 -: LUT_BITS]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_vld     <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_idx     <= '0;
            r_s2_vld     <= 1'b0;
            r_s2_sign    <= 1'b0;
            r_s2_mag     <= '0;
            o_dout_valid <= 1'b0;
            o_dout       <= '0;
        end else begin
            r_s1_vld     <= w_issue;
            r_s1_sign    <= w_addr_i[LUT_BITS-1];
            r_s1_idx     <= w_addr_i[LUT_BITS-2:0];
            r_s2_vld     <= r_s1_vld;
            r_s2_sign    <= r_s1_sign;
            r_s2_mag     <= w_rom[r_s1_idx];
            o_dout_valid <= r_s2_vld;
            if (r_s2_vld) begin
                o_dout <= r_s2_sign ? -r_s2_mag : r_s2_mag;
            end else begin
                o_dout <= '0;
            end
        end
    end

`ifdef DDS_IQ_EN
    // +90 degrees only touches the top two phase bits.
    logic [LUT_BITS-1:0]  w_ptop_q;
    logic [LUT_BITS-1:0]  w_addr_q;
    logic                 r_s1q_sign;
    logic [LUT_BITS-2:0]  r_s1q_idx;
    logic                 r_s2q_sign;
    logic [OUT_WIDTH-1:0] r_s2q_mag;

    assign w_ptop_q = r_phase[N_PHASE-1 -: LUT_BITS] + {2'b01, {(LUT_BITS-2){1'b0}}};
    assign w_addr_q = f_lut_addr(w_ptop_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1q_sign <= 1'b0;
            r_s1q_idx  <= '0;
            r_s2q_sign <= 1'b0;
            r_s2q_mag  <= '0;
            o_dout_q   <= '0;
        end else begin
            r_s1q_sign <= w_addr_q[LUT_BITS-1];
            r_s1q_idx  <= w_addr_q[LUT_BITS-2:0];
            r_s2q_sign <= r_s1q_sign;
            r_s2q_mag  <= w_rom[r_s1q_idx];
            if (r_s2_vld) begin
                o_dout_q <= r_s2q_sign ? -r_s2q_mag : r_s2q_mag;
            end else begin
                o_dout_q <= '0;
            end
        end
    end
`endif

endmodule
